// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared types and constants for the SPI memory transaction controller.
//   state_t     : controller state encoding (3 bits, IDLE = 0)
//   RW_READ     : value of the R/W bit that selects a read frame
//   DATA_W_DEF  : default frame/data width
//   ADDR_W_DEF  : default address width (DATA_W_DEF - 1)
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    localparam int   DATA_W_DEF = 8;
    localparam int   ADDR_W_DEF = 7;
    localparam logic RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        GET_ADDR     = 3'd1,
        LATCH_ADDR   = 3'd2,
        READ_LOAD    = 3'd3,
        READ_SHIFT   = 3'd4,
        WRITE_GET    = 3'd5,
        WRITE_COMMIT = 3'd6,
        DONE         = 3'd7
    } state_t;

endpackage

// File: rtl/spi_mem_fsm_if.sv
// -----------------------------------------------------------------------------
// spi_mem_fsm_if
// Bus bundle between the SPI input conditioners / shift register and the
// transaction controller.
//   cs_n, sclk_pe, sclk_ne : conditioned chip select and serial-clock edge pulses
//   sr_pout                : shift-register parallel output
//   sr_load, dm_we         : one-clk strobes to shift register / data memory
//   addr                   : latched memory address
//   miso_en, busy          : MISO enable, controller-active flag
//   abort_err              : sticky abort flag (only with SPI_MEM_FSM_ABORT_EN)
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface spi_mem_fsm_if
    import spi_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              cs_n;
    logic              sclk_pe;
    logic              sclk_ne;
    logic [DATA_W-1:0] sr_pout;
    logic              sr_load;
    logic              dm_we;
    logic [ADDR_W-1:0] addr;
    logic              miso_en;
    logic              busy;
`ifdef SPI_MEM_FSM_ABORT_EN
    logic              abort_err;
`endif

    modport slave (
        input  cs_n, sclk_pe, sclk_ne, sr_pout,
        output sr_load, dm_we, addr, miso_en, busy
`ifdef SPI_MEM_FSM_ABORT_EN
        , output abort_err
`endif
    );

    modport master (
        output cs_n, sclk_pe, sclk_ne, sr_pout,
        input  sr_load, dm_we, addr, miso_en, busy
`ifdef SPI_MEM_FSM_ABORT_EN
        , input abort_err
`endif
    );

endinterface

// File: rtl/spi_bit_counter.sv
// -----------------------------------------------------------------------------
// spi_bit_counter
// Bit counter shared by the address, read-shift and write-data phases.
//   clk, reset : system clock, synchronous active-high reset
//   i_clr      : clear to zero (priority over increment)
//   i_inc      : count one relevant serial-clock edge
//   o_last     : the edge being counted this cycle is the DATA_W-th
// -----------------------------------------------------------------------------
module spi_bit_counter
    import spi_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The terminating edge is flagged while it is being counted, so the
    // owning state leaves (and clears the count) instead of reaching DATA_W+1.
    assign o_last = i_inc && (r_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/spi_mem_fsm.sv
// -----------------------------------------------------------------------------
// spi_mem_fsm
// SPI memory transaction controller: decodes each frame (address, R/W bit,
// data) from conditioned chip-select / serial-clock edge pulses and the
// shift-register parallel output.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_mem_fsm_if.slave (cs_n, sclk_pe, sclk_ne, sr_pout in;
//                sr_load, dm_we, addr, miso_en, busy [, abort_err] out)
// Optional feature macro: SPI_MEM_FSM_ABORT_EN adds the sticky abort_err flag.
// All outputs are registered from the next state, so an abort (cs_n high)
// suppresses any strobe that would otherwise have been issued.
// -----------------------------------------------------------------------------
module spi_mem_fsm
    import spi_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    spi_mem_fsm_if.slave   bus
);

    state_t            r_state;
    state_t            w_next;
    logic              w_inc;
    logic              w_clr;
    logic              w_last;
    logic              r_armed;
    logic              r_sr_load;
    logic              r_dm_we;
    logic              r_miso_en;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;

    spi_bit_counter #(.DATA_W(DATA_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_last (w_last)
    );

    // Only the edge relevant to the current phase is counted.
    always_comb begin
        w_inc = 1'b0;
        case (r_state)
            GET_ADDR, WRITE_GET: w_inc = bus.sclk_pe;
            READ_SHIFT:          w_inc = bus.sclk_ne;
            default:             w_inc = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         if (!bus.cs_n && r_armed) w_next = GET_ADDR;
            GET_ADDR:     if (w_last) w_next = LATCH_ADDR;
            LATCH_ADDR:   w_next = (bus.sr_pout[0] == RW_READ) ? READ_LOAD : WRITE_GET;
            READ_LOAD:    w_next = READ_SHIFT;
            READ_SHIFT:   if (w_last) w_next = DONE;
            WRITE_GET:    if (w_last) w_next = WRITE_COMMIT;
            WRITE_COMMIT: w_next = DONE;
            DONE:         if (bus.cs_n) w_next = IDLE;
            default:      w_next = IDLE;
        endcase
        // Chip-select release overrides every other transition.
        if (bus.cs_n && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    // Counter restarts on every state change.
    assign w_clr = (w_next != r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_armed   <= 1'b0;
            r_sr_load <= 1'b0;
            r_dm_we   <= 1'b0;
            r_miso_en <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_next;
            r_sr_load <= (w_next == READ_LOAD);
            r_dm_we   <= (w_next == WRITE_COMMIT);
            r_miso_en <= (w_next == READ_SHIFT);
            r_busy    <= (w_next != IDLE);
            // A frame may only start after cs_n has been seen high since reset.
            if (bus.cs_n) begin
                r_armed <= 1'b1;
            end
            if ((r_state == LATCH_ADDR) && !bus.cs_n) begin
                r_addr <= bus.sr_pout[DATA_W-1:1];
            end
        end
    end

`ifdef SPI_MEM_FSM_ABORT_EN
    logic r_abort_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_abort_err <= 1'b0;
        end else if (bus.cs_n && (r_state != IDLE) && (r_state != DONE)) begin
            r_abort_err <= 1'b1;
        end
    end

    assign bus.abort_err = r_abort_err;
`endif

    assign bus.sr_load = r_sr_load;
    assign bus.dm_we   = r_dm_we;
    assign bus.miso_en = r_miso_en;
    assign bus.busy    = r_busy;
    assign bus.addr    = r_addr;

endmodule

// File: tb/tb_spi_mem_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_fsm
// Randomized frame stimulus for spi_mem_fsm. The driver computes, from the
// frame contents, which strobes must appear, with which address and on which
// cycle, and queues them; the monitor pops and compares whenever the DUT
// raises dm_we or sr_load, or closes a miso_en window.
// Define SPI_MEM_FSM_ABORT_EN to also check the abort_err flag.
// -----------------------------------------------------------------------------
module tb_spi_mem_fsm;
    import spi_mem_pkg::*;

    localparam int DW = 8;
    localparam int AW = 7;

    typedef enum int {EV_WR = 0, EV_RD = 1, EV_MISO = 2} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [AW-1:0] addr;
        int unsigned cyc;
        int unsigned n;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    ev_t         sb[$];
    logic [AW-1:0] model_addr = '0;
`ifdef SPI_MEM_FSM_ABORT_EN
    logic        model_abort = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mem_fsm_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    spi_mem_fsm #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // ---------------- monitor ----------------
    logic        p_dm = 1'b0, p_sl = 1'b0, p_miso = 1'b0;
    int unsigned sl_cyc = 0;
    int unsigned ne_cnt = 0;

    task automatic expect_ev(input ev_kind_t k, input int unsigned n);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", 32'(k) + 1, 0);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", 32'(k), 32'(e.kind));
            if (k == EV_MISO) begin
                chk("miso_ne_count", n, e.n);
            end else begin
                chk("ev_addr", 32'(bus.addr), 32'(e.addr));
                chk("ev_cycle", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.dm_we === 1'b1) begin
            chk("dm_we_one_clk", 32'(p_dm), 0);
            if (!p_dm) expect_ev(EV_WR, 0);
        end
        if (bus.sr_load === 1'b1) begin
            chk("sr_load_one_clk", 32'(p_sl), 0);
            if (!p_sl) begin
                expect_ev(EV_RD, 0);
                sl_cyc = cyc;
            end
        end
        if (bus.miso_en === 1'b1 && !p_miso) chk("miso_after_load", cyc, sl_cyc + 1);
        if (bus.miso_en === 1'b1 && bus.sclk_ne === 1'b1) ne_cnt++;
        if (bus.miso_en === 1'b0 && p_miso) begin
            expect_ev(EV_MISO, ne_cnt);
            ne_cnt = 0;
        end
        p_dm   = (bus.dm_we === 1'b1);
        p_sl   = (bus.sr_load === 1'b1);
        p_miso = (bus.miso_en === 1'b1);
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit pe, input bit ne);
        bus.sclk_pe = pe;
        bus.sclk_ne = ne;
        tick();
        bus.sclk_pe = 1'b0;
        bus.sclk_ne = 1'b0;
    endtask

    // Issue `target` relevant edges (pe, or ne when use_ne) with random gaps,
    // stray irrelevant edges and simultaneous pe+ne. last_cyc = cycle in
    // which the final relevant edge was presented.
    task automatic count_edges(input bit use_ne, input int unsigned target, output int unsigned last_cyc);
        int unsigned got;
        int unsigned r;
        got = 0;
        last_cyc = cyc;
        while (got < target) begin
            repeat ($urandom_range(0, 2)) tick();
            r = $urandom_range(0, 5);
            if (r == 0) begin
                pulse(use_ne, !use_ne);
            end else begin
                last_cyc = cyc;
                if (r == 1) pulse(1'b1, 1'b1);
                else        pulse(!use_ne, use_ne);
                got++;
            end
        end
    endtask

    // One complete frame. abort_n < DW aborts a write after abort_n data edges.
    task automatic frame(input logic [AW-1:0] a, input bit rw, input int unsigned abort_n);
        int unsigned k;
        bus.sr_pout = DW'($urandom);
        bus.cs_n = 1'b0;
        tick();
        count_edges(1'b0, DW, k);
        bus.sr_pout = {a, rw};
        model_addr = a;
        if (rw) begin
            sb.push_back('{kind: EV_RD, addr: a, cyc: k + 2, n: 0});
            sb.push_back('{kind: EV_MISO, addr: a, cyc: 0, n: DW});
        end
        tick();
        bus.sr_pout = DW'($urandom);
        if (rw) begin
            tick();
            count_edges(1'b1, DW, k);
        end else if (abort_n < DW) begin
            count_edges(1'b0, abort_n, k);
            bus.cs_n = 1'b1;
            tick();
            chk("abort_busy", 32'(bus.busy), 0);
            chk("abort_addr", 32'(bus.addr), 32'(model_addr));
`ifdef SPI_MEM_FSM_ABORT_EN
            model_abort = 1'b1;
            chk("abort_err_set", 32'(bus.abort_err), 32'(model_abort));
`endif
            tick();
            return;
        end else begin
            count_edges(1'b0, DW, k);
            sb.push_back('{kind: EV_WR, addr: a, cyc: k + 1, n: 0});
        end
        repeat (2) pulse(1'b1, 1'b1);
        chk("done_busy", 32'(bus.busy), 1);
        bus.cs_n = 1'b1;
        tick();
        chk("end_idle", 32'(bus.busy), 0);
        chk("addr_hold", 32'(bus.addr), 32'(model_addr));
`ifdef SPI_MEM_FSM_ABORT_EN
        chk("abort_err", 32'(bus.abort_err), 32'(model_abort));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        logic [AW-1:0] a;
        bit rw;
        int unsigned ab;

        reset = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk_pe = 1'b0;
        bus.sclk_ne = 1'b0;
        bus.sr_pout = '0;
        repeat (3) tick();
        chk("rst_sr_load", 32'(bus.sr_load), 0);
        chk("rst_dm_we",   32'(bus.dm_we), 0);
        chk("rst_miso_en", 32'(bus.miso_en), 0);
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_addr",    32'(bus.addr), 0);
`ifdef SPI_MEM_FSM_ABORT_EN
        chk("rst_abort_err", 32'(bus.abort_err), 0);
`endif
        reset = 1'b0;
        tick();

        // Write 8'hA4 (addr 7'h52), then back-to-back read 8'h0F (addr 7'h07).
        frame(7'h52, 1'b0, DW);
        frame(7'h07, 1'b1, DW);
        // Write aborted after 5 data edges.
        frame(7'h2D, 1'b0, 5);

        // Reset during the third serial-clock period of READ_SHIFT.
        a = 7'h33;
        bus.cs_n = 1'b0;
        tick();
        count_edges(1'b0, DW, k);
        bus.sr_pout = {a, 1'b1};
        sb.push_back('{kind: EV_RD, addr: a, cyc: k + 2, n: 0});
        sb.push_back('{kind: EV_MISO, addr: a, cyc: 0, n: 3});
        tick();
        bus.sr_pout = DW'($urandom);
        tick();
        count_edges(1'b1, 3, k);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_addr = '0;
        chk("midrst_sr_load", 32'(bus.sr_load), 0);
        chk("midrst_dm_we",   32'(bus.dm_we), 0);
        chk("midrst_miso_en", 32'(bus.miso_en), 0);
        chk("midrst_busy",    32'(bus.busy), 0);
        chk("midrst_addr",    32'(bus.addr), 32'(model_addr));
`ifdef SPI_MEM_FSM_ABORT_EN
        model_abort = 1'b0;
        chk("midrst_abort_err", 32'(bus.abort_err), 32'(model_abort));
`endif
        // cs_n still low: not re-armed yet.
        repeat (4) begin
            pulse(1'b1, 1'b0);
            chk("unarmed_busy", 32'(bus.busy), 0);
        end
        bus.cs_n = 1'b1;
        tick();
        frame(7'h61, 1'b1, DW);

        // Spurious edges with chip select high.
        repeat (10) begin
            pulse(1'b1, 1'($urandom_range(0, 1)));
            chk("spurious_busy", 32'(bus.busy), 0);
        end

        // Random frames.
        repeat (12) begin
            a  = AW'($urandom);
            rw = 1'($urandom_range(0, 1));
            ab = (!rw && $urandom_range(0, 3) == 0) ? $urandom_range(0, DW - 1) : DW;
            frame(a, rw, ab);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
